// File: rtl/pc_seq_if.sv
// Fetch handshake between the PC sequencer (master) and the instruction fetch unit (slave).
interface pc_seq_if;
   logic        if_req;
   logic        if_ready;
   logic [31:0] pc;

   modport master (output if_req, output pc, input if_ready);
   modport slave  (input if_req, input pc, output if_ready);
endinterface

// File: rtl/pc_seq.sv
// Fetch-side PC sequencer: sequential fetch, branch/jump redirect with MIPS delay slot,
// fetch handshake and decode-stall handling; drives the immediate extender from ID.
module pc_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        rst_n,
   pc_seq_if.master    fetch,
   input  logic        id_valid,
   input  logic [31:0] inst,
   input  logic        stall,
   output logic [2:0]  ext_op,
   output logic [25:0] ext_din,
   input  logic [31:0] ext,
   input  logic [31:0] rs_data,
   input  logic        br_cond,
   output logic        redirect
);

   typedef enum logic [2:0] {
      EXT_NONE = 3'b000,
      EXT_Z    = 3'b001,
      EXT_S    = 3'b010,
      EXT_B    = 3'b011,
      EXT_J    = 3'b100,
      EXT_L    = 3'b101,
      EXT_I    = 3'b110
   } ext_op_e;

   typedef enum logic [0:0] {
      SEQ  = 1'b0,
      SLOT = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] tgt_q, tgt_d;
   logic        in_slot_q, in_slot_d;
   logic        redirect_q, redirect_d;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   ext_op_e     ext_op_c;
   logic        is_jr;
   logic        accept;
   logic        take;
   logic [31:0] id_pc_plus4;
   logic [31:0] target;

   assign opcode  = inst[31:26];
   assign funct   = inst[5:0];
   assign ext_din = inst[25:0];
   assign ext_op  = ext_op_c;

   always_comb begin
      ext_op_c = EXT_NONE;
      case (opcode)
         6'b000000: begin
            if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011)
               ext_op_c = EXT_I;
         end
         6'b001000, 6'b001001, 6'b001010, 6'b001011,
         6'b100000, 6'b100011, 6'b100100, 6'b101000, 6'b101011: ext_op_c = EXT_S;
         6'b001100, 6'b001101, 6'b001110:                       ext_op_c = EXT_Z;
         6'b001111:                                             ext_op_c = EXT_L;
         6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111: ext_op_c = EXT_B;
         6'b000010, 6'b000011:                                  ext_op_c = EXT_J;
         default:                                               ext_op_c = EXT_NONE;
      endcase
   end

   assign is_jr       = (opcode == 6'b000000) && (funct == 6'b001000 || funct == 6'b001001);
   assign fetch.if_req = rst_n & ~stall;
   assign fetch.pc    = pc_q;
   assign accept      = fetch.if_req & fetch.if_ready;
   assign id_pc_plus4 = id_pc_q + 32'd4;
   assign redirect    = redirect_q;

   always_comb begin
      target = rs_data;
      if (ext_op_c == EXT_B)
         target = id_pc_plus4 + ext;
      else if (ext_op_c == EXT_J)
         target = {id_pc_plus4[31:28], ext[27:0]};
   end

   // A transfer sitting in a delay slot, or decoded while a target is already pending, is ignored.
   assign take = (state_q == SEQ) & id_valid & ~stall & ~in_slot_q &
                 (((ext_op_c == EXT_B) & br_cond) | (ext_op_c == EXT_J) | is_jr);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      id_pc_d    = id_pc_q;
      tgt_d      = tgt_q;
      in_slot_d  = in_slot_q;
      redirect_d = 1'b0;
      if (accept) begin
         id_pc_d   = pc_q;
         in_slot_d = 1'b0;
      end
      case (state_q)
         SEQ: begin
            if (accept && take) begin
               pc_d       = target;
               redirect_d = 1'b1;
               in_slot_d  = 1'b1;
            end else if (accept) begin
               pc_d = pc_q + 32'd4;
            end else if (take) begin
               tgt_d   = target;
               state_d = SLOT;
            end
         end
         SLOT: begin
            if (accept) begin
               pc_d       = tgt_q;
               redirect_d = 1'b1;
               in_slot_d  = 1'b1;
               state_d    = SEQ;
            end
         end
         default: state_d = SEQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= SEQ;
         pc_q       <= RESET_PC;
         id_pc_q    <= RESET_PC;
         tgt_q      <= '0;
         in_slot_q  <= 1'b0;
         redirect_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_pc_q    <= id_pc_d;
         tgt_q      <= tgt_d;
         in_slot_q  <= in_slot_d;
         redirect_q <= redirect_d;
      end
   end

endmodule
